// File: rtl/arrow_round_scheduler.sv
// arrow_round_scheduler: sequences arrow-game rounds. Each round spawns an arrow,
// opens a tick-timed hit window, judges the button presses, updates score and
// combo, then blanks the display for a gap before the next spawn.
// Optional feature macro: DOUBLE_ARROW_EN (two-button arrows, codes 14..19).
module arrow_round_scheduler #(
  parameter int         WINDOW_TICKS = 4,
  parameter int         GAP_TICKS    = 1,
  parameter int         COMBO_STEP   = 5,
  parameter logic [4:0] ARROW_UP     = 5'd10,
  parameter logic [4:0] ARROW_DOWN   = 5'd11,
  parameter logic [4:0] ARROW_LEFT   = 5'd12,
  parameter logic [4:0] ARROW_RIGHT  = 5'd13,
  parameter logic [4:0] ARROW_NONE   = 5'd20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] game_state_i,
  input  logic       tick_i,
  input  logic [5:0] rand_i,
  input  logic [3:0] btn_i,
  output logic [4:0] arrow_code_o,
  output logic [7:0] score_o,
  output logic [7:0] combo_o,
  output logic       hit_o,
  output logic       miss_o,
  output logic       combo_hit_o
);

`ifdef DOUBLE_ARROW_EN
  localparam logic [4:0] ARROW_UP_DOWN = 5'd14;
`endif

  localparam logic [3:0] WIN_T = 4'(WINDOW_TICKS);
  localparam logic [3:0] GAP_T = 4'(GAP_TICKS);

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_WAIT, S_HIT, S_MISS, S_GAP} state_t;

  state_t     state_q;
  logic [3:0] req_q, pressed_q, cnt_q;
  logic [4:0] arrow_q;
  logic [7:0] score_q, combo_q;
  logic       hit_q, miss_q, chit_q;

  logic       in_game, in_reset;
  logic [3:0] spawn_mask, pressed_d, cnt_d;
  logic [4:0] spawn_code;
  logic [7:0] score_d, combo_d;
  logic       wrong, milestone;

  assign in_game   = (game_state_i == 2'd0);
  assign in_reset  = (game_state_i == 2'd2);
  assign pressed_d = pressed_q | btn_i;
  assign wrong     = |(btn_i & ~req_q);
  assign cnt_d     = cnt_q + 4'd1;
  assign score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  assign combo_d   = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
  assign milestone = (combo_d != 8'd0) && ((int'(combo_d) % COMBO_STEP) == 0);

  // Decode the random value into the required button mask and display code.
  always_comb begin
    spawn_mask = 4'b0001;
    spawn_code = ARROW_UP;
    unique case (rand_i[1:0])
      2'd0: begin spawn_mask = 4'b0001; spawn_code = ARROW_UP;    end
      2'd1: begin spawn_mask = 4'b0010; spawn_code = ARROW_DOWN;  end
      2'd2: begin spawn_mask = 4'b0100; spawn_code = ARROW_LEFT;  end
      default: begin spawn_mask = 4'b1000; spawn_code = ARROW_RIGHT; end
    endcase
`ifdef DOUBLE_ARROW_EN
    if (rand_i[5] && (rand_i[4:2] < 3'd6)) begin
      spawn_code = ARROW_UP_DOWN + 5'(rand_i[4:2]);
      unique case (rand_i[4:2])
        3'd0:    spawn_mask = 4'b0011;
        3'd1:    spawn_mask = 4'b0101;
        3'd2:    spawn_mask = 4'b1001;
        3'd3:    spawn_mask = 4'b0110;
        3'd4:    spawn_mask = 4'b1010;
        default: spawn_mask = 4'b1100;
      endcase
    end
`endif
  end

`ifndef DOUBLE_ARROW_EN
  logic unused_rand;
  assign unused_rand = ^rand_i[5:2];
`endif

  // Round FSM with registered outputs; only GAME advances, RESET clears, PAUSE holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE; req_q <= '0; pressed_q <= '0; cnt_q <= '0;
      arrow_q <= ARROW_NONE; score_q <= '0; combo_q <= '0;
      hit_q <= 1'b0; miss_q <= 1'b0; chit_q <= 1'b0;
    end else if (in_reset) begin
      state_q <= S_IDLE; req_q <= '0; pressed_q <= '0; cnt_q <= '0;
      arrow_q <= ARROW_NONE; score_q <= '0; combo_q <= '0;
      hit_q <= 1'b0; miss_q <= 1'b0; chit_q <= 1'b0;
    end else if (in_game) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      chit_q <= 1'b0;
      unique case (state_q)
        S_IDLE: state_q <= S_SPAWN;
        S_SPAWN: begin
          req_q     <= spawn_mask;
          arrow_q   <= spawn_code;
          cnt_q     <= '0;
          pressed_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          pressed_q <= pressed_d;
          // Wrong button beats everything; a completing press beats the timeout tick.
          if (wrong) begin
            miss_q <= 1'b1; state_q <= S_MISS;
          end else if (pressed_d == req_q) begin
            hit_q <= 1'b1; state_q <= S_HIT;
          end else if (tick_i) begin
            cnt_q <= cnt_d;
            if (cnt_d == WIN_T) begin
              miss_q <= 1'b1; state_q <= S_MISS;
            end
          end
        end
        S_HIT: begin
          score_q <= score_d;
          combo_q <= combo_d;
          chit_q  <= milestone;
          arrow_q <= ARROW_NONE;
          cnt_q   <= '0;
          state_q <= S_GAP;
        end
        S_MISS: begin
          combo_q <= '0;
          arrow_q <= ARROW_NONE;
          cnt_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (tick_i) begin
            cnt_q <= cnt_d;
            if (cnt_d == GAP_T) state_q <= S_SPAWN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pulses are suppressed whenever the game is not running.
  assign arrow_code_o = arrow_q;
  assign score_o      = score_q;
  assign combo_o      = combo_q;
  assign hit_o        = hit_q  & in_game;
  assign miss_o       = miss_q & in_game;
  assign combo_hit_o  = chit_q & in_game;

endmodule

// File: tb/tb_arrow_round_scheduler.sv
// Bench for arrow_round_scheduler: table of hand-computed rounds, hand-written
// pause/reset sequences, then randomized rounds against a round-level model.
module tb_arrow_round_scheduler;
  localparam int WINDOW = 4;
  localparam int GAP    = 1;
  localparam int STEP   = 5;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] game_state_i;
  logic       tick_i;
  logic [5:0] rand_i;
  logic [3:0] btn_i;
  logic [4:0] arrow_code_o;
  logic [7:0] score_o, combo_o;
  logic       hit_o, miss_o, combo_hit_o;

  arrow_round_scheduler #(.WINDOW_TICKS(WINDOW), .GAP_TICKS(GAP), .COMBO_STEP(STEP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .game_state_i(game_state_i), .tick_i(tick_i),
    .rand_i(rand_i), .btn_i(btn_i), .arrow_code_o(arrow_code_o), .score_o(score_o),
    .combo_o(combo_o), .hit_o(hit_o), .miss_o(miss_o), .combo_hit_o(combo_hit_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;
  int mscore = 0;
  int mcombo = 0;

  typedef struct {
    logic [5:0] r;
    int         mode;   // 0 press after k ticks, 1 wrong after k ticks, 2 timeout,
                        // 3 press with final tick, 4 wrong with final tick
    int         k;
    int         code;
    bit         hit;
    int         score;
    int         combo;
    bit         chit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic t, input logic [3:0] b);
    tick_i = t;
    btn_i  = b;
    step();
    tick_i = 1'b0;
    btn_i  = 4'b0;
  endtask

  task automatic wait_arrow();
    int i;
    for (i = 0; i < 40; i++) begin
      if (arrow_code_o != 5'd20) break;
      step();
    end
    n_chk++;
    if (i == 40) $display("FAIL spawn_timeout: got no arrow after %0d cycles, expected one", i);
    else n_pass++;
  endtask

  // Arrow rules: direction index d in {up,down,left,right} -> code 10+d, button 1<<d.
  function automatic void decode(input logic [5:0] r, output int code, output logic [3:0] mask);
`ifdef DOUBLE_ARROW_EN
    int pa[6] = '{0, 0, 0, 1, 1, 2};
    int pb[6] = '{1, 2, 3, 2, 3, 3};
`endif
    code = 10 + int'(r[1:0]);
    mask = 4'(1 << r[1:0]);
`ifdef DOUBLE_ARROW_EN
    if (r[5] && r[4:2] < 3'd6) begin
      code = 14 + int'(r[4:2]);
      mask = 4'((1 << pa[r[4:2]]) | (1 << pb[r[4:2]]));
    end
`endif
  endfunction

  function automatic logic [3:0] wrong_btn(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[i]) return 4'(1 << i);
    return 4'b0;
  endfunction

  task automatic after_judge(input logic [3:0] gb, input int escore, input int ecombo, input bit echit);
    chk("hit_width", hit_o, 0);
    chk("miss_width", miss_o, 0);
    chk("score", score_o, escore);
    chk("combo", combo_o, ecombo);
    chk("combo_hit", combo_hit_o, echit);
    chk("gap_arrow", arrow_code_o, 20);
    repeat (GAP) pulse(1'b1, gb);
  endtask

  task automatic round(input logic [5:0] r, input int mode, input int k, input logic [3:0] gb,
                       input int ecode, input bit ehit, input int escore, input int ecombo,
                       input bit echit);
    int c;
    logic [3:0] m;
    decode(r, c, m);
    rand_i = r;
    wait_arrow();
    chk("spawn_code", arrow_code_o, ecode);
    case (mode)
      0: begin repeat (k) pulse(1'b1, 4'b0); pulse(1'b0, m); end
      1: begin repeat (k) pulse(1'b1, 4'b0); pulse(1'b0, wrong_btn(m)); end
      2: repeat (WINDOW) pulse(1'b1, 4'b0);
      3: begin repeat (WINDOW - 1) pulse(1'b1, 4'b0); pulse(1'b1, m); end
      default: begin repeat (WINDOW - 1) pulse(1'b1, 4'b0); pulse(1'b1, wrong_btn(m)); end
    endcase
    chk("hit_pulse", hit_o, ehit);
    chk("miss_pulse", miss_o, !ehit);
    pulse(1'b0, gb);
    after_judge(gb, escore, ecombo, echit);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{6'd2,  0, 1, 12, 1, 1, 1, 0};
    tbl[1] = '{6'd0,  2, 0, 10, 0, 1, 0, 0};
    tbl[2] = '{6'd0,  3, 0, 10, 1, 2, 1, 0};
    tbl[3] = '{6'd61, 0, 0, 11, 1, 3, 2, 0};
    tbl[4] = '{6'd3,  0, 3, 13, 1, 4, 3, 0};
    tbl[5] = '{6'd1,  0, 2, 11, 1, 5, 4, 0};
    tbl[6] = '{6'd2,  0, 0, 12, 1, 6, 5, 1};
    tbl[7] = '{6'd3,  1, 0, 13, 0, 6, 0, 0};
    tbl[8] = '{6'd2,  4, 0, 12, 0, 6, 0, 0};
    tbl[9] = '{6'd0,  0, 1, 10, 1, 7, 1, 0};

    rst_i = 1'b1; game_state_i = 2'd0; tick_i = 1'b0; rand_i = '0; btn_i = '0;
    step(); step();
    chk("rst_arrow", arrow_code_o, 20);
    chk("rst_score", score_o, 0);
    chk("rst_combo", combo_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_miss", miss_o, 0);
    chk("rst_combo_hit", combo_hit_o, 0);
    rst_i = 1'b0;

    foreach (tbl[i])
      round(tbl[i].r, tbl[i].mode, tbl[i].k, 4'b0, tbl[i].code, tbl[i].hit,
            tbl[i].score, tbl[i].combo, tbl[i].chit);

    // Pause while the hit pulse is up: pulse hidden, state held, then resumes.
    rand_i = 6'd1;
    wait_arrow();
    chk("p_code", arrow_code_o, 11);
    pulse(1'b0, 4'b0010);
    chk("p_hit", hit_o, 1);
    game_state_i = 2'd1; #1;
    chk("p_hit_masked", hit_o, 0);
    step();
    chk("p_hit_held", hit_o, 0);
    chk("p_score_frozen", score_o, 7);
    game_state_i = 2'd0; #1;
    chk("p_hit_resumed", hit_o, 1);
    step();
    after_judge(4'b0, 8, 2, 0);

    // Pause mid-window for 10 ticks with presses; window count must resume at 2.
    rand_i = 6'd0;
    wait_arrow();
    chk("pw_code", arrow_code_o, 10);
    pulse(1'b1, 4'b0); pulse(1'b1, 4'b0);
    game_state_i = 2'd1;
    repeat (10) pulse(1'b1, 4'b0001);
    chk("pw_arrow", arrow_code_o, 10);
    chk("pw_no_hit", hit_o, 0);
    game_state_i = 2'd3;
    pulse(1'b1, 4'b0001);
    chk("pw3_no_hit", hit_o, 0);
    game_state_i = 2'd0;
    pulse(1'b1, 4'b0);
    chk("pw_tick3_no_miss", miss_o, 0);
    pulse(1'b1, 4'b0);
    chk("pw_tick4_miss", miss_o, 1);
    pulse(1'b0, 4'b0);
    after_judge(4'b0, 8, 0, 0);

    // Synchronous RESET game state mid-window, then restart from IDLE.
    rand_i = 6'd1;
    wait_arrow();
    pulse(1'b1, 4'b0);
    game_state_i = 2'd2;
    pulse(1'b0, 4'b0010);
    chk("gr_arrow", arrow_code_o, 20);
    chk("gr_score", score_o, 0);
    chk("gr_combo", combo_o, 0);
    chk("gr_hit", hit_o, 0);
    game_state_i = 2'd0;
    pulse(1'b0, 4'b0);
    chk("gr_idle_arrow", arrow_code_o, 20);
    pulse(1'b0, 4'b0);
    chk("gr_spawn_arrow", arrow_code_o, 11);
    pulse(1'b0, 4'b0010);
    chk("gr_hit2", hit_o, 1);
    pulse(1'b0, 4'b0);
    after_judge(4'b0, 1, 1, 0);

    // Asynchronous reset in the middle of a window, with a correct press held.
    rand_i = 6'd3;
    wait_arrow();
    pulse(1'b1, 4'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_arrow_async", arrow_code_o, 20);
    chk("ar_score_async", score_o, 0);
    chk("ar_combo_async", combo_o, 0);
    btn_i = 4'b1000;
    step();
    chk("ar_hit", hit_o, 0);
    chk("ar_miss", miss_o, 0);
    chk("ar_arrow", arrow_code_o, 20);
    rst_i = 1'b0; btn_i = 4'b0;
    mscore = 0; mcombo = 0;

`ifdef DOUBLE_ARROW_EN
    // Two-button arrow (up+right): split presses hit, a foreign press misses.
    rand_i = 6'b101000;
    wait_arrow();
    chk("d_code", arrow_code_o, 16);
    pulse(1'b0, 4'b0001);
    chk("d_half_no_hit", hit_o, 0);
    chk("d_half_no_miss", miss_o, 0);
    pulse(1'b0, 4'b1000);
    chk("d_hit", hit_o, 1);
    pulse(1'b0, 4'b0);
    after_judge(4'b0, 1, 1, 0);
    wait_arrow();
    chk("d_code2", arrow_code_o, 16);
    pulse(1'b0, 4'b0001);
    pulse(1'b0, 4'b0010);
    chk("d_miss", miss_o, 1);
    pulse(1'b0, 4'b0);
    after_judge(4'b0, 1, 0, 0);
    mscore = 1; mcombo = 0;
`endif

    // Randomized rounds against the round-level model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] r;
      logic [3:0] m;
      int mode, k, code;
      bit ehit, echit;
      r    = 6'($urandom);
      mode = $urandom_range(0, 4);
      k    = $urandom_range(0, WINDOW - 1);
      decode(r, code, m);
      ehit = (mode == 0) || (mode == 3);
      echit = 1'b0;
      if (ehit) begin
        if (mscore < 255) mscore++;
        if (mcombo < 255) mcombo++;
        echit = (mcombo % STEP) == 0;
      end else begin
        mcombo = 0;
      end
      round(r, mode, k, 4'($urandom), code, ehit, mscore, mcombo, echit);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
